// File: rtl/mtm_alu_deserializer_out_if.sv
// Serial result link: `sin` comes from the ALU output serializer, and the decoded packet
// fields go to the downstream consumer.
interface mtm_alu_deserializer_out_if;
   logic        sin;
   logic        out_valid;
   logic [31:0] out_data;
   logic [3:0]  out_flags;
   logic [5:0]  out_err_flags;
   logic [1:0]  out_status;

   modport master (
      output sin,
      input  out_valid, out_data, out_flags, out_err_flags, out_status
   );

   modport slave (
      input  sin,
      output out_valid, out_data, out_flags, out_err_flags, out_status
   );
endinterface

// File: rtl/mtm_alu_deserializer_out.sv
// Deserializer for the ALU result stream. It rebuilds 11-bit frames, groups them into
// data or error packets, checks CRC and parity, and reports one registered strobe per packet.
module mtm_alu_deserializer_out #(
   parameter int MAX_GAP = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   mtm_alu_deserializer_out_if.slave bus
);
   localparam int            GW        = (MAX_GAP < 1) ? 1 : $clog2(MAX_GAP + 1);
   localparam logic [GW-1:0] GAP_LIMIT = GW'(MAX_GAP);
   localparam logic [1:0]    ST_DATA_OK  = 2'b00;
   localparam logic [1:0]    ST_ERR_OK   = 2'b01;
   localparam logic [1:0]    ST_CHK_FAIL = 2'b10;
   localparam logic [1:0]    ST_PROTO    = 2'b11;

   typedef enum logic [2:0] {
      S_SYNC = 3'd0,
      S_IDLE = 3'd1,
      S_TYPE = 3'd2,
      S_DATA = 3'd3,
      S_STOP = 3'd4
   } state_t;

   function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic d);
      logic fb;
      fb = crc[2] ^ d;
      return {crc[1], crc[0] ^ fb, fb};
   endfunction

   function automatic logic ctl_parity(input logic [7:0] b);
      return 1'b1 ^ (^b[7:1]);
   endfunction

   state_t         state_q, state_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic           type_q, type_d;
   logic [7:0]     shift_q, shift_d;
   logic [2:0]     idx_q, idx_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [2:0]     crc_q, crc_d;
   logic [31:0]    data_q, data_d;
   logic           valid_q, valid_d;
   logic [31:0]    odata_q, odata_d;
   logic [3:0]     oflags_q, oflags_d;
   logic [5:0]     oerr_q, oerr_d;
   logic [1:0]     ostat_q, ostat_d;
   logic           crc_en;

   // The CRC covers the four payload bytes and then the top five bits of the closing CTL byte.
   assign crc_en = (!type_q && (idx_q < 3'd4)) ||
                   (type_q && (idx_q == 3'd4) && (bit_cnt_q < 3'd5));

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      type_d    = type_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      crc_d     = crc_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      odata_d   = odata_q;
      oflags_d  = oflags_q;
      oerr_d    = oerr_q;
      ostat_d   = ostat_q;
      case (state_q)
         S_SYNC: begin
            if (bus.sin) state_d = S_IDLE;
            else         state_d = S_SYNC;
         end
         S_IDLE: begin
            if (!bus.sin) begin
               state_d   = S_TYPE;
               gap_d     = {GW{1'b0}};
               bit_cnt_d = 3'd0;
               if (idx_q == 3'd0) crc_d = 3'd0;
               else               crc_d = crc_q;
            end else if (idx_q != 3'd0) begin
               if (gap_q == GAP_LIMIT) begin
                  valid_d = 1'b1;
                  ostat_d = ST_PROTO;
                  idx_d   = 3'd0;
                  gap_d   = {GW{1'b0}};
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end else begin
               gap_d = {GW{1'b0}};
            end
         end
         S_TYPE: begin
            type_d  = bus.sin;
            state_d = S_DATA;
         end
         S_DATA: begin
            shift_d   = {shift_q[6:0], bus.sin};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (crc_en) crc_d = crc3_step(crc_q, bus.sin);
            else        crc_d = crc_q;
            if (bit_cnt_q == 3'd7) state_d = S_STOP;
            else                   state_d = S_DATA;
         end
         S_STOP: begin
            if (!bus.sin) begin
               valid_d = 1'b1;
               ostat_d = ST_PROTO;
               idx_d   = 3'd0;
               gap_d   = {GW{1'b0}};
               state_d = S_SYNC;
            end else begin
               state_d = S_IDLE;
               if (idx_q == 3'd0) begin
                  if (type_q) begin
                     valid_d = 1'b1;
                     if (shift_q[7]) begin
                        oerr_d  = shift_q[6:1];
                        ostat_d = (ctl_parity(shift_q) == shift_q[0]) ? ST_ERR_OK : ST_CHK_FAIL;
                     end else begin
                        ostat_d = ST_PROTO;
                     end
                  end else begin
                     data_d = {data_q[23:0], shift_q};
                     idx_d  = 3'd1;
                  end
               end else if (idx_q < 3'd4) begin
                  if (type_q) begin
                     valid_d = 1'b1;
                     ostat_d = ST_PROTO;
                     idx_d   = 3'd0;
                  end else begin
                     data_d = {data_q[23:0], shift_q};
                     idx_d  = idx_q + 3'd1;
                  end
               end else begin
                  valid_d = 1'b1;
                  idx_d   = 3'd0;
                  // Payload and flags are shown even when the CRC check fails.
                  if (type_q && !shift_q[7]) begin
                     odata_d  = data_q;
                     oflags_d = shift_q[6:3];
                     ostat_d  = (crc_q == shift_q[2:0]) ? ST_DATA_OK : ST_CHK_FAIL;
                  end else begin
                     ostat_d = ST_PROTO;
                  end
               end
            end
         end
         default: begin
            state_d = S_SYNC;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_SYNC;
         bit_cnt_q <= 3'd0;
         type_q    <= 1'b0;
         shift_q   <= 8'd0;
         idx_q     <= 3'd0;
         gap_q     <= {GW{1'b0}};
         crc_q     <= 3'd0;
         data_q    <= 32'd0;
         valid_q   <= 1'b0;
         odata_q   <= 32'd0;
         oflags_q  <= 4'd0;
         oerr_q    <= 6'd0;
         ostat_q   <= 2'b00;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         type_q    <= type_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         crc_q     <= crc_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         odata_q   <= odata_d;
         oflags_q  <= oflags_d;
         oerr_q    <= oerr_d;
         ostat_q   <= ostat_d;
      end
   end

   assign bus.out_valid     = valid_q;
   assign bus.out_data      = odata_q;
   assign bus.out_flags     = oflags_q;
   assign bus.out_err_flags = oerr_q;
   assign bus.out_status    = ostat_q;
endmodule

// File: tb/tb_mtm_alu_deserializer_out.sv
// Self-checking bench for mtm_alu_deserializer_out. Every out_valid pulse is captured together
// with the bit that caused it, then compared against packet-level expectations.
module tb_mtm_alu_deserializer_out;
   localparam int MAX_GAP = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mtm_alu_deserializer_out_if bus();
   mtm_alu_deserializer_out #(.MAX_GAP(MAX_GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int          at;
      logic [31:0] d;
      logic [3:0]  f;
      logic [5:0]  e;
      logic [1:0]  s;
   } pulse_t;

   typedef struct {
      string       name;
      bit          is_err;
      logic [31:0] c;
      logic [3:0]  fl;
      logic [2:0]  crc_xor;
      logic [7:0]  ctl;
      logic [1:0]  exp_st;
      logic [5:0]  exp_err;
   } vec_t;

   pulse_t      pq[$];
   vec_t        vt[$];
   int          nbit = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] m_data = 32'd0;
   logic [3:0]  m_flags = 4'd0;
   logic [5:0]  m_err = 6'd0;

   // CRC as the polynomial remainder of {C,0,FLAGS}*x^3 modulo x^3+x+1.
   function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] fl);
      logic [39:0] v;
      v = {c, 1'b0, fl, 3'b000};
      for (int i = 39; i >= 3; i--) begin
         if (v[i]) v = v ^ (40'hB << (i - 3));
      end
      return v[2:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sample();
      pulse_t p;
      if (bus.out_valid === 1'b1) begin
         p.at = nbit - 1;
         p.d  = bus.out_data;
         p.f  = bus.out_flags;
         p.e  = bus.out_err_flags;
         p.s  = bus.out_status;
         pq.push_back(p);
      end
   endtask

   task automatic drive(input logic b);
      @(negedge clk);
      sample();
      bus.sin = b;
      nbit++;
   endtask

   task automatic set_rst(input logic r, input logic b);
      @(negedge clk);
      sample();
      rst = r;
      bus.sin = b;
      nbit++;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1);
   endtask

   task automatic send_frame(input logic typ, input logic [7:0] b, input logic stp, output int at);
      drive(1'b0);
      drive(typ);
      for (int i = 7; i >= 0; i--) drive(b[i]);
      drive(stp);
      at = nbit - 1;
   endtask

   task automatic send_data_pkt(input logic [31:0] c, input logic [3:0] fl, input logic [2:0] crc,
                                input int gap, output int at);
      logic [31:0] sh;
      sh = c;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) idle(gap);
         send_frame(1'b0, sh[31:24], 1'b1, at);
         sh = sh << 8;
      end
      idle(gap);
      send_frame(1'b1, {1'b0, fl, crc}, 1'b1, at);
   endtask

   // kind: 0 data packet, 1 error packet, 2 no field update.
   task automatic expect_pulse(input string name, input int at, input logic [1:0] st, input int kind,
                               input logic [31:0] d, input logic [3:0] f, input logic [5:0] e);
      pulse_t p;
      if (kind == 0 && st != 2'b11) begin
         m_data  = d;
         m_flags = f;
      end
      if (kind == 1 && st != 2'b11) m_err = e;
      if (pq.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: no out_valid pulse, expected one after bit %0d", name, at);
      end else begin
         p = pq.pop_front();
         chk({name, ".at"},     p.at, at);
         chk({name, ".status"}, {30'd0, p.s}, {30'd0, st});
         chk({name, ".data"},   p.d, m_data);
         chk({name, ".flags"},  {28'd0, p.f}, {28'd0, m_flags});
         chk({name, ".err"},    {26'd0, p.e}, {26'd0, m_err});
      end
   endtask

   task automatic expect_none(input string name);
      chk({name, ".extra_pulses"}, pq.size(), 0);
      pq.delete();
   endtask

   task automatic add_vec(input string name, input bit is_err, input logic [31:0] c,
                          input logic [3:0] fl, input logic [2:0] crc_xor, input logic [7:0] ctl,
                          input logic [1:0] exp_st, input logic [5:0] exp_err);
      vec_t v;
      v.name = name; v.is_err = is_err; v.c = c; v.fl = fl; v.crc_xor = crc_xor;
      v.ctl = ctl; v.exp_st = exp_st; v.exp_err = exp_err;
      vt.push_back(v);
   endtask

   initial begin
      int at, at2;
      logic [31:0] c, c2;
      logic [3:0]  fl, fl2;
      logic [2:0]  crc, crc2;
      int gap, pos;

      rst = 1'b1;
      bus.sin = 1'b1;

      add_vec("data_zero",   1'b0, 32'h0000_0000, 4'h0, 3'd0, 8'h00, 2'b00, 6'd0);
      add_vec("err_c8",      1'b1, 32'd0,         4'h0, 3'd0, 8'hC8, 2'b01, 6'b100100);
      add_vec("err_c9",      1'b1, 32'd0,         4'h0, 3'd0, 8'hC9, 2'b10, 6'b100100);
      add_vec("data_ones",   1'b0, 32'hFFFF_FFFF, 4'hF, 3'd0, 8'h00, 2'b00, 6'd0);
      add_vec("err_80",      1'b1, 32'd0,         4'h0, 3'd0, 8'h80, 2'b01, 6'b000000);
      add_vec("data_badcrc", 1'b0, 32'h1234_5678, 4'h5, 3'd4, 8'h00, 2'b10, 6'd0);
      add_vec("err_81",      1'b1, 32'd0,         4'h0, 3'd0, 8'h81, 2'b10, 6'b000000);
      add_vec("data_edges",  1'b0, 32'h8000_0001, 4'hA, 3'd0, 8'h00, 2'b00, 6'd0);
      add_vec("err_fe",      1'b1, 32'd0,         4'h0, 3'd0, 8'hFE, 2'b01, 6'b111111);
      add_vec("err_ff",      1'b1, 32'd0,         4'h0, 3'd0, 8'hFF, 2'b10, 6'b111111);
      add_vec("ctl_first",   1'b1, 32'd0,         4'h0, 3'd0, 8'h3C, 2'b11, 6'd0);
      add_vec("data_crc1",   1'b0, 32'hCAFE_BABE, 4'h9, 3'd1, 8'h00, 2'b10, 6'd0);

      repeat (3) set_rst(1'b1, 1'b1);
      chk("reset.valid",  {31'd0, bus.out_valid}, 32'd0);
      chk("reset.data",   bus.out_data, 32'd0);
      chk("reset.flags",  {28'd0, bus.out_flags}, 32'd0);
      chk("reset.err",    {26'd0, bus.out_err_flags}, 32'd0);
      chk("reset.status", {30'd0, bus.out_status}, 32'd0);
      set_rst(1'b0, 1'b1);

      for (int i = 0; i < vt.size(); i++) begin
         idle(2);
         if (vt[i].is_err) begin
            send_frame(1'b1, vt[i].ctl, 1'b1, at);
            idle(1);
            expect_pulse(vt[i].name, at, vt[i].exp_st, 1, 32'd0, 4'd0, vt[i].exp_err);
         end else begin
            send_data_pkt(vt[i].c, vt[i].fl, ref_crc(vt[i].c, vt[i].fl) ^ vt[i].crc_xor, 0, at);
            idle(1);
            expect_pulse(vt[i].name, at, vt[i].exp_st, 0, vt[i].c, vt[i].fl, 6'd0);
         end
      end
      expect_none("table");

      // A stop bit of 0 aborts the packet, and the line must go high before new frames are accepted.
      idle(2);
      send_frame(1'b0, 8'hA5, 1'b1, at);
      send_frame(1'b0, 8'h5A, 1'b0, at);
      repeat (5) drive(1'b0);
      expect_pulse("framing", at, 2'b11, 2, 32'd0, 4'd0, 6'd0);
      expect_none("framing.sync");
      idle(2);
      send_data_pkt(32'hCAFE_F00D, 4'h3, ref_crc(32'hCAFE_F00D, 4'h3), 0, at);
      idle(1);
      expect_pulse("after_framing", at, 2'b00, 0, 32'hCAFE_F00D, 4'h3, 6'd0);

      idle(1);
      send_frame(1'b0, 8'h11, 1'b1, at);
      send_frame(1'b1, 8'h22, 1'b1, at);
      idle(1);
      expect_pulse("ctl_second", at, 2'b11, 2, 32'd0, 4'd0, 6'd0);
      send_data_pkt(32'h0BAD_BEEF, 4'hC, ref_crc(32'h0BAD_BEEF, 4'hC), 1, at);
      idle(1);
      expect_pulse("after_ctl_second", at, 2'b00, 0, 32'h0BAD_BEEF, 4'hC, 6'd0);

      send_data_pkt(32'h5555_AAAA, 4'h6, ref_crc(32'h5555_AAAA, 4'h6), MAX_GAP, at);
      idle(1);
      expect_pulse("gap_max_ok", at, 2'b00, 0, 32'h5555_AAAA, 4'h6, 6'd0);

      send_frame(1'b0, 8'h01, 1'b1, at);
      send_frame(1'b0, 8'h02, 1'b1, at);
      send_frame(1'b0, 8'h03, 1'b1, at);
      idle(MAX_GAP + 2);
      expect_pulse("gap_timeout", at + MAX_GAP + 1, 2'b11, 2, 32'd0, 4'd0, 6'd0);
      expect_none("gap_timeout");

      for (int k = 0; k < 5; k++) send_frame(1'b0, 8'h40 + 8'(k), 1'b1, at);
      idle(1);
      expect_pulse("data_fifth", at, 2'b11, 2, 32'd0, 4'd0, 6'd0);

      // Two packets with no idle between them.
      send_data_pkt(32'h0102_0304, 4'h1, ref_crc(32'h0102_0304, 4'h1), 0, at);
      send_data_pkt(32'hF0E0_D0C0, 4'h8, ref_crc(32'hF0E0_D0C0, 4'h8), 0, at2);
      idle(1);
      expect_pulse("b2b_first", at, 2'b00, 0, 32'h0102_0304, 4'h1, 6'd0);
      expect_pulse("b2b_second", at2, 2'b00, 0, 32'hF0E0_D0C0, 4'h8, 6'd0);

      // Reset arrives in the middle of payload bits while the line is low.
      drive(1'b0); drive(1'b0); drive(1'b1); drive(1'b0);
      set_rst(1'b1, 1'b0);
      set_rst(1'b1, 1'b0);
      m_data = 32'd0; m_flags = 4'd0; m_err = 6'd0;
      chk("rst_mid.data",   bus.out_data, 32'd0);
      chk("rst_mid.flags",  {28'd0, bus.out_flags}, 32'd0);
      chk("rst_mid.status", {30'd0, bus.out_status}, 32'd0);
      set_rst(1'b0, 1'b0);
      repeat (3) drive(1'b0);
      expect_none("rst_mid.quiet");
      chk("rst_mid.valid_low", {31'd0, bus.out_valid}, 32'd0);
      idle(1);
      send_data_pkt(32'h1357_9BDF, 4'h7, ref_crc(32'h1357_9BDF, 4'h7), 0, at);
      idle(1);
      expect_pulse("after_reset", at, 2'b00, 0, 32'h1357_9BDF, 4'h7, 6'd0);

      for (int n = 0; n < 300; n++) begin
         c   = $urandom;
         fl  = 4'($urandom_range(0, 15));
         gap = ($urandom_range(0, 9) == 0) ? MAX_GAP : $urandom_range(0, 2);
         crc = ref_crc(c, fl);
         send_data_pkt(c, fl, crc, gap, at);
         c2 = c; fl2 = fl; crc2 = crc;
         pos = $urandom_range(0, 38);
         if (pos < 32)      c2[pos]        = ~c2[pos];
         else if (pos < 36) fl2[pos - 32]  = ~fl2[pos - 32];
         else               crc2[pos - 36] = ~crc2[pos - 36];
         idle($urandom_range(0, 2));
         send_data_pkt(c2, fl2, crc2, gap, at2);
         idle(1 + $urandom_range(0, 2));
         expect_pulse("rand_clean", at, (ref_crc(c, fl) == crc) ? 2'b00 : 2'b10, 0, c, fl, 6'd0);
         expect_pulse("rand_flip", at2, (ref_crc(c2, fl2) == crc2) ? 2'b00 : 2'b10, 0, c2, fl2, 6'd0);
      end
      expect_none("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
